// File: rtl/mem_io_responder_pkg.sv
// Shared address map and decode helper for the memory/I-O responder.
package mem_io_responder_pkg;

  // Address bits 17:16 equal to this value select the I/O window
  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO_DATA,
    REGION_IO_CLK,
    REGION_IO_OTHER
  } region_e;

  // Classify an 18-bit byte address; the clock window covers four bytes
  function automatic region_e decodeRegion(input logic [17:0] addr);
    if (addr[17:16] != IO_REGION) begin
      return REGION_RAM;
    end else if (addr == IO_DATA_ADDR) begin
      return REGION_IO_DATA;
    end else if (addr[17:2] == IO_CLK_ADDR[17:2]) begin
      return REGION_IO_CLK;
    end else begin
      return REGION_IO_OTHER;
    end
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Small byte FIFO with extra-MSB pointers; used for both host RX and TX.
module byte_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wrPtr_q, wrPtr_d;
  logic [FIFO_AW:0] rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                   (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);

  // A full FIFO refuses pushes even if it is popped in the same cycle
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q[FIFO_AW-1:0]];

  assign wrPtr_d = wrPtr_q + {{FIFO_AW{1'b0}}, doPush};
  assign rdPtr_d = rdPtr_q + {{FIFO_AW{1'b0}}, doPop};

  // Pointer registers; reset empties the FIFO without touching storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage write at the current tail slot
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q[FIFO_AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128KB byte RAM plus I/O window with RX/TX byte
// FIFOs, a free-running cycle counter with snapshot, and a sticky halt flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt
);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ramIdx;

  logic [7:0]  memDin_q, memDin_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        halt_q, halt_d;

  region_e     region;
  logic        accept, rdAccept, wrAccept;
  logic        rxFull, rxEmpty, rxPop;
  logic [7:0]  rxHead;
  logic        txFull, txEmpty, txPush;
  logic [7:0]  txHead;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^mem_a[31:18];

  assign region   = decodeRegion(mem_a[17:0]);
  assign ramIdx   = mem_a[RAM_AW-1:0];

  // The cpu is only frozen by a full TX FIFO, so rdy_out comes straight
  // from FIFO pointer registers and never from the incoming address
  assign accept   = !txFull;
  assign rdAccept = accept && !mem_wr;
  assign wrAccept = accept && mem_wr;

  assign rxPop    = rdAccept && (region == REGION_IO_DATA);
  assign txPush   = wrAccept && (region == REGION_IO_DATA) && (mem_dout != 8'h00);

  byte_fifo #(.FIFO_AW(FIFO_AW)) rxFifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (rxPop),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .head_o  (rxHead)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) txFifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (txPush),
    .data_i  (mem_dout),
    .pop_i   (tx_ready),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .head_o  (txHead)
  );

  // Read-data mux, snapshot capture, counter increment and halt latch
  always_comb begin
    memDin_d   = memDin_q;
    snapshot_d = snapshot_q;
    counter_d  = counter_q + 32'd1;
    halt_d     = halt_q;
    if (wrAccept && (mem_a[17:0] == IO_CLK_ADDR)) begin
      halt_d = 1'b1;
    end
    if (rdAccept) begin
      unique case (region)
        REGION_RAM:     memDin_d = ram[ramIdx];
        REGION_IO_DATA: memDin_d = rxEmpty ? 8'h00 : rxHead;
        REGION_IO_CLK: begin
          unique case (mem_a[1:0])
            2'd0: begin
              memDin_d   = counter_q[7:0];
              snapshot_d = counter_q;
            end
            2'd1:    memDin_d = snapshot_q[15:8];
            2'd2:    memDin_d = snapshot_q[23:16];
            default: memDin_d = snapshot_q[31:24];
          endcase
        end
        default:        memDin_d = 8'h00;
      endcase
    end
  end

  // Control-state registers, all cleared by the asynchronous reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      memDin_q   <= 8'h00;
      counter_q  <= 32'd0;
      snapshot_q <= 32'd0;
      halt_q     <= 1'b0;
    end else begin
      memDin_q   <= memDin_d;
      counter_q  <= counter_d;
      snapshot_q <= snapshot_d;
      halt_q     <= halt_d;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (wrAccept && (region == REGION_RAM)) begin
      ram[ramIdx] <= mem_dout;
    end
  end

  assign mem_din  = memDin_q;
  assign rdy_out  = !txFull;
  assign rx_ready = !rxFull;
  assign tx_valid = !txEmpty;
  assign tx_data  = txHead;
  assign halt     = halt_q;

endmodule
